// File: rtl/sev_seg_rx.sv
// Receiver for a multiplexed active-low seven-segment bus: synchronises seg/an, qualifies each digit
// over STABLE strobes and decodes it back to BCD. Define SEV_SEG_RX_HEX_EN to also accept the A-F glyphs.

module sev_seg_rx #(
   parameter int DIGITS  = 4,
   parameter int STABLE  = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  err,
   output logic                  frame_valid
);

   localparam int              TW         = $clog2(TIMEOUT);
   localparam logic [TW-1:0]   TO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [3:0]      STB        = 4'(STABLE);
   localparam logic [1:0]      KIND_HIT   = 2'd0;
   localparam logic [1:0]      KIND_BLANK = 2'd1;
   localparam logic [1:0]      KIND_BAD   = 2'd2;

   // Returns {kind, value}; blank and unknown glyphs both carry 4'hF so hex F stays distinct via digit_valid.
   function automatic logic [5:0] decodeSeg(input logic [6:0] s);
      case (s)
         7'b0000001: decodeSeg = {KIND_HIT, 4'h0};
         7'b1001111: decodeSeg = {KIND_HIT, 4'h1};
         7'b0010010: decodeSeg = {KIND_HIT, 4'h2};
         7'b0000110: decodeSeg = {KIND_HIT, 4'h3};
         7'b1001100: decodeSeg = {KIND_HIT, 4'h4};
         7'b0100100: decodeSeg = {KIND_HIT, 4'h5};
         7'b0100000: decodeSeg = {KIND_HIT, 4'h6};
         7'b0001111: decodeSeg = {KIND_HIT, 4'h7};
         7'b0000000: decodeSeg = {KIND_HIT, 4'h8};
         7'b0000100: decodeSeg = {KIND_HIT, 4'h9};
`ifdef SEV_SEG_RX_HEX_EN
         7'b0001000: decodeSeg = {KIND_HIT, 4'hA};
         7'b1100000: decodeSeg = {KIND_HIT, 4'hB};
         7'b0110001: decodeSeg = {KIND_HIT, 4'hC};
         7'b1000010: decodeSeg = {KIND_HIT, 4'hD};
         7'b0110000: decodeSeg = {KIND_HIT, 4'hE};
         7'b0111000: decodeSeg = {KIND_HIT, 4'hF};
`endif
         7'b1111111: decodeSeg = {KIND_BLANK, 4'hF};
         default:    decodeSeg = {KIND_BAD, 4'hF};
      endcase
   endfunction

   logic [6:0]                segS1_q, segS2_q;
   logic [DIGITS-1:0]         anS1_q, anS2_q;
   logic [DIGITS-1:0][6:0]    lastPat_q, lastPat_d;
   logic [DIGITS-1:0][3:0]    cnt_q, cnt_d;
   logic [4*DIGITS-1:0]       digits_q, digits_d;
   logic [DIGITS-1:0]         valid_q, valid_d;
   logic [DIGITS-1:0]         mask_q, mask_d;
   logic                      err_q, err_d;
   logic                      frame_q, frame_d;
   logic [TW-1:0]             toCnt_q, toCnt_d;

   logic [DIGITS-1:0]         anLow;
   logic                      strobe;
   logic [DIGITS-1:0]         strobeVec;
   logic [DIGITS-1:0]         acceptVec;
   logic [5:0]                segDec;
   logic                      stale;

   assign anLow     = ~anS2_q;
   assign strobe    = (anLow != '0) && ((anLow & (anLow - DIGITS'(1))) == '0);
   assign strobeVec = strobe ? anLow : '0;
   assign segDec    = decodeSeg(segS2_q);

   // A digit accepts only on the strobe that brings its run length up to STABLE, never while saturated.
   always_comb begin
      acceptVec = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (strobeVec[i]) begin
            if (segS2_q == lastPat_q[i]) begin
               acceptVec[i] = (cnt_q[i] == STB - 4'd1);
            end else begin
               acceptVec[i] = (STB == 4'd1);
            end
         end
      end
   end

   always_comb begin
      lastPat_d = lastPat_q;
      cnt_d     = cnt_q;
      digits_d  = digits_q;
      valid_d   = valid_q;
      mask_d    = mask_q;
      toCnt_d   = toCnt_q;
      err_d     = 1'b0;
      frame_d   = 1'b0;
      stale     = 1'b0;

      if (&mask_q) begin
         mask_d  = '0;
         frame_d = &valid_q;
      end

      for (int i = 0; i < DIGITS; i++) begin
         if (strobeVec[i]) begin
            if (segS2_q == lastPat_q[i]) begin
               if (cnt_q[i] != STB) begin
                  cnt_d[i] = cnt_q[i] + 4'd1;
               end
            end else begin
               lastPat_d[i] = segS2_q;
               cnt_d[i]     = 4'd1;
            end
         end
         if (acceptVec[i]) begin
            digits_d[4*i +: 4] = segDec[3:0];
            valid_d[i]         = (segDec[5:4] == KIND_HIT);
            mask_d[i]          = (segDec[5:4] != KIND_BAD);
            err_d              = (segDec[5:4] == KIND_BAD);
         end
      end

      // Stale only triggers while no strobe is present, so it never collides with an acceptance.
      if (strobe) begin
         toCnt_d = '0;
      end else if (toCnt_q != TO_LAST) begin
         toCnt_d = toCnt_q + TW'(1);
         stale   = (toCnt_q == TO_LAST - TW'(1));
      end

      if (stale) begin
         digits_d = '1;
         valid_d  = '0;
         mask_d   = '0;
         cnt_d    = '0;
         frame_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segS1_q   <= '0;
         segS2_q   <= '0;
         anS1_q    <= '0;
         anS2_q    <= '0;
         lastPat_q <= '0;
         cnt_q     <= '0;
         digits_q  <= '1;
         valid_q   <= '0;
         mask_q    <= '0;
         err_q     <= 1'b0;
         frame_q   <= 1'b0;
         toCnt_q   <= '0;
      end else begin
         segS1_q   <= seg;
         segS2_q   <= segS1_q;
         anS1_q    <= an;
         anS2_q    <= anS1_q;
         lastPat_q <= lastPat_d;
         cnt_q     <= cnt_d;
         digits_q  <= digits_d;
         valid_q   <= valid_d;
         mask_q    <= mask_d;
         err_q     <= err_d;
         frame_q   <= frame_d;
         toCnt_q   <= toCnt_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign err         = err_q;
   assign frame_valid = frame_q;

endmodule
